// File: rtl/uart_tx_pkg.sv
// Shared state encoding, line-level constants and the parity helper for the UART frame controller.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  function automatic logic parity_bit(input logic par_typ, input logic red);
    return (par_typ == PAR_ODD) ? ~red : red;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit for the accepted byte: XOR reduction of the data, captured on the accept strobe.
module uart_parity_calc #(
  parameter int Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [Width-1:0] i_data,
  input  logic             i_par_typ,
  output logic             o_par_bit
);
  import uart_tx_pkg::*;

  logic w_red;
  logic w_par_next;
  logic r_par_bit;

  assign w_red      = ^i_data;
  assign w_par_next = parity_bit(i_par_typ, w_red);

  // The parity type is folded into the stored bit, so no separate copy of it is kept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_par_bit <= 1'b0;
    end else if (i_en) begin
      r_par_bit <= w_par_next;
    end
  end

  assign o_par_bit = r_par_bit;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: start, Width data bits from the serializer, optional parity, stop.
// Optional macro UART_TX_TWO_STOP_EN adds a second stop bit (STOP2).
//
//   state  | meaning
//   IDLE   | line high, waiting for data_valid
//   START  | start bit, serializer shifts bit0
//   DATA   | serial data on line until ser_done
//   PARITY | parity bit on line
//   STOP   | stop bit, back-to-back accept allowed (single stop)
//   STOP2  | second stop bit, back-to-back accept allowed
module uart_tx_fsm #(
  parameter int Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_p_data,
  input  logic             i_data_valid,
  input  logic             i_par_en,
  input  logic             i_par_typ,
  input  logic             i_ser_data,
  input  logic             i_ser_done,
  output logic             o_ser_en,
  output logic             o_tx_out,
  output logic             o_busy
);
  import uart_tx_pkg::*;

  tx_state_e r_state;
  tx_state_e w_state_next;
  logic      r_par_en_q;
  logic      w_accept;
  logic      w_par_bit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_par_en_q <= 1'b0;
    end else if (w_accept) begin
      r_par_en_q <= i_par_en;
    end
  end

  uart_parity_calc #(
    .Width(Width)
  ) u_parity (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_accept),
    .i_data   (i_p_data),
    .i_par_typ(i_par_typ),
    .o_par_bit(w_par_bit)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    o_tx_out     = LINE_IDLE;
    o_ser_en     = 1'b0;
    o_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_data_valid) begin
          w_accept     = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        o_tx_out     = START_BIT;
        o_ser_en     = !i_ser_done;
        w_state_next = DATA;
      end
      DATA: begin
        o_tx_out = i_ser_data;
        o_ser_en = !i_ser_done;
        if (i_ser_done) begin
          w_state_next = r_par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        o_tx_out     = w_par_bit;
        w_state_next = STOP;
      end
`ifdef UART_TX_TWO_STOP_EN
      STOP: begin
        w_state_next = STOP2;
      end
      STOP2: begin
        if (i_data_valid) begin
          w_accept     = 1'b1;
          w_state_next = START;
        end else begin
          w_state_next = IDLE;
        end
      end
`else
      STOP: begin
        // The serializer is idle here (ser_en low), so it loads alongside the accept.
        if (i_data_valid) begin
          w_accept     = 1'b1;
          w_state_next = START;
        end else begin
          w_state_next = IDLE;
        end
      end
`endif
      default: begin
        o_busy       = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: serializer stand-in, frame-level expected-line queue, random traffic.
module tb_uart_tx_fsm;
  localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int FRAME = W + 1 + NSTOP;

  typedef struct packed {
    logic tx;
    logic busy;
    logic sen;
    logic last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_en;
  logic         par_typ;
  logic         ser_data;
  logic         ser_done;
  logic         ser_en;
  logic         tx_out;
  logic         busy;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  logic hist_tx[$];
  logic hist_busy[$];

  uart_tx_fsm #(.Width(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_p_data    (p_data),
    .i_data_valid(data_valid),
    .i_par_en    (par_en),
    .i_par_typ   (par_typ),
    .i_ser_data  (ser_data),
    .i_ser_done  (ser_done),
    .o_ser_en    (ser_en),
    .o_tx_out    (tx_out),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // Serializer stand-in: loads when idle, shifts LSB first, done after W shifts.
  logic [W-1:0] s_sh;
  int           s_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sh     <= '0;
      s_cnt    <= 0;
      ser_data <= 1'b0;
    end else if (data_valid && !ser_en) begin
      s_sh  <= p_data;
      s_cnt <= 0;
    end else if (ser_en && s_cnt < W) begin
      ser_data <= s_sh[0];
      s_sh     <= s_sh >> 1;
      s_cnt    <= s_cnt + 1;
    end
  end
  assign ser_done = (s_cnt == W);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic tx, input logic b, input logic s, input logic l);
    exp_t e;
    e.tx   = tx;
    e.busy = b;
    e.sen  = s;
    e.last = l;
    return e;
  endfunction

  task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
    q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < W; i++) q.push_back(mk(d[i], 1'b1, (i != W - 1), 1'b0));
    if (pe) q.push_back(mk(pt ? ~(^d) : (^d), 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < NSTOP; i++) q.push_back(mk(1'b1, 1'b1, 1'b0, (i == NSTOP - 1)));
  endtask

  // Called at a falling edge: check this cycle, update the model, drive next inputs.
  task automatic step(input logic dv, input logic [W-1:0] d, input logic pe, input logic pt);
    exp_t cur;
    if (q.size() > 0) cur = q.pop_front();
    else cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tx_out", tx_out, cur.tx);
    chk("busy", busy, cur.busy);
    chk("ser_en", ser_en, cur.sen);
    hist_tx.push_back(tx_out);
    hist_busy.push_back(busy);
    if (dv && (!cur.busy || cur.last)) push_frame(d, pe, pt);
    data_valid = dv;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  function automatic int busy_cnt(input int idx, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (hist_busy[idx + i]) c++;
    return c;
  endfunction

  function automatic logic [31:0] tx_vec(input int idx, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], hist_tx[idx + i]};
    return v;
  endfunction

  initial begin
    int idx;
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    #2;
    chk("rst_tx", tx_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ser_en", ser_en, 1'b0);
    #10 rst = 1'b0;
    @(negedge clk);
    idle(5);

    // 0xA5 without parity
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    idx = hist_tx.size();
    idle(14);
    chk("a5_seq", tx_vec(idx, 10), 32'b0101001011);
    chk("a5_busy_len", busy_cnt(idx, 14), FRAME);

    // 0x03 even then odd parity
    step(1'b1, 8'h03, 1'b1, 1'b0);
    idx = hist_tx.size();
    idle(15);
    chk("par_even_bit", hist_tx[idx + W + 1], 1'b0);
    chk("par_even_len", busy_cnt(idx, 15), FRAME + 1);
    step(1'b1, 8'h03, 1'b1, 1'b1);
    idx = hist_tx.size();
    idle(15);
    chk("par_odd_bit", hist_tx[idx + W + 1], 1'b1);
    chk("par_odd_len", busy_cnt(idx, 15), FRAME + 1);

    // back-to-back: second request in the last stop cycle
    step(1'b1, 8'h55, 1'b0, 1'b0);
    idx = hist_tx.size();
    idle(W + NSTOP);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    idle(14);
    chk("b2b_busy", busy_cnt(idx, 2 * FRAME + 2), 2 * FRAME);
    chk("b2b_seq1", tx_vec(idx, 10), 32'b0101010101);
    chk("b2b_start2", hist_tx[idx + FRAME], 1'b0);
    chk("b2b_seq2", tx_vec(idx + FRAME, 10), 32'b0000011111);

    // async reset during data bit 4
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    idle(5);
    chk("pre_rst_bit4", tx_out, 1'b0);
    chk("pre_rst_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx_out, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ser_en", ser_en, 1'b0);
    q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    step(1'b1, 8'h96, 1'b1, 1'b1);
    idx = hist_tx.size();
    idle(15);
    chk("post_rst_seq", tx_vec(idx, 11), 32'b00110100111);

    // requests during DATA and PARITY are ignored
    step(1'b1, 8'h5A, 1'b1, 1'b1);
    idx = hist_tx.size();
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) step((i % 2) == 0, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    idle(14);
    chk("ign_par_bit", hist_tx[idx + W + 1], 1'b1);
    chk("ign_seq", tx_vec(idx, 11), 32'b00101101011);
    chk("ign_busy_len", busy_cnt(idx, 16), FRAME + 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) == 0, W'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
